// File: rtl/alu_host_pkg.sv
// Shared types and constants for the host-side ALU command initiator.
// The issue_pins helper maps one queued command onto the ALU control pins.
package alu_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic       unit;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       irq_clr;
  } cmd_t;

  typedef struct packed {
    logic       en;
    logic       en_a;
    logic       en_b;
    logic [1:0] op_a;
    logic [1:0] op_b;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       irq_clr;
  } alu_pins_t;

  localparam logic       UNIT_A      = 1'b0;
  localparam logic       UNIT_B      = 1'b1;
  localparam logic [7:0] IRQ_CNT_MAX = 8'd255;

  // The unselected unit keeps enable and op at 0 so it never sees a stray op.
  function automatic alu_pins_t issue_pins(input cmd_t c);
    alu_pins_t p;
    p         = '0;
    p.en      = 1'b1;
    p.en_a    = (c.unit == UNIT_A);
    p.en_b    = (c.unit == UNIT_B);
    p.op_a    = (c.unit == UNIT_A) ? c.op : 2'b00;
    p.op_b    = (c.unit == UNIT_B) ? c.op : 2'b00;
    p.in_a    = c.a;
    p.in_b    = c.b;
    p.irq_clr = c.irq_clr;
    return p;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty,
// so a full FIFO never accepts a push even if it pops in the same cycle.
module alu_cmd_fifo
  import alu_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  cmd_t                   data_i,
  output cmd_t                   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t              mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_host_ctrl.sv
// Host-side ALU command initiator: FIFO-buffered commands, one-cycle ALU pin
// pulse per command, captured result returned over a response handshake.
module alu_host_ctrl
  import alu_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   alu_clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_unit,
  input  logic [1:0]             cmd_op,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  input  logic                   cmd_irq_clr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic                   rsp_irq,
  output logic [7:0]             irq_cnt,
  output logic                   alu_enable,
  output logic                   alu_enable_a,
  output logic                   alu_enable_b,
  output logic                   alu_irq_clr,
  output logic [1:0]             alu_op_a,
  output logic [1:0]             alu_op_b,
  output logic [7:0]             alu_in_a,
  output logic [7:0]             alu_in_b,
  input  logic [7:0]             alu_out,
  input  logic                   alu_irq,
  output state_e                 dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a held rsp_valid keeps rsp_data/rsp_irq stable until rsp_ready is seen.

  state_e    state_q;
  alu_pins_t pins_q;
  alu_pins_t issue_pins_d;
  logic      rsp_valid_q;
  logic      rsp_irq_q;
  logic [7:0] rsp_data_q;
  logic [7:0] irq_cnt_q;

  cmd_t fifo_din;
  cmd_t fifo_dout;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;

  assign cmd_ready = !fifo_full && !rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_din  = '{unit: cmd_unit, op: cmd_op, a: cmd_a, b: cmd_b, irq_clr: cmd_irq_clr};
  assign issue_pins_d = issue_pins(fifo_dout);

  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: fifo_pop = !fifo_empty;
      ST_RESP: fifo_pop = rsp_ready && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (alu_clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (dbg_count)
  );

  // Pins default to 0 every cycle, so a load lasts exactly the ISSUE cycle.
  always_ff @(posedge alu_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pins_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_irq_q   <= 1'b0;
      irq_cnt_q   <= '0;
    end else begin
      pins_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pins_q  <= issue_pins_d;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          rsp_data_q  <= alu_out;
          rsp_irq_q   <= alu_irq;
          rsp_valid_q <= 1'b1;
          if (alu_irq && (irq_cnt_q != IRQ_CNT_MAX)) irq_cnt_q <= irq_cnt_q + 8'd1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!fifo_empty) begin
              pins_q  <= issue_pins_d;
              state_q <= ST_ISSUE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_irq      = rsp_irq_q;
  assign irq_cnt      = irq_cnt_q;
  assign alu_enable   = pins_q.en;
  assign alu_enable_a = pins_q.en_a;
  assign alu_enable_b = pins_q.en_b;
  assign alu_irq_clr  = pins_q.irq_clr;
  assign alu_op_a     = pins_q.op_a;
  assign alu_op_b     = pins_q.op_b;
  assign alu_in_a     = pins_q.in_a;
  assign alu_in_b     = pins_q.in_b;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_host_ctrl.sv
// Bench for alu_host_ctrl: registered ALU model, random and directed commands,
// scoreboard of expected responses and issued pin sets checked by a monitor.
module tb_alu_host_ctrl;
  import alu_host_pkg::*;

  localparam int DEPTH = 4;

  logic       alu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_unit = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_irq_clr = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_irq;
  logic [7:0] irq_cnt;
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b;
  logic [7:0] alu_out;
  logic       alu_irq;
  state_e     dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  alu_host_ctrl #(.DEPTH(DEPTH)) dut (
    .alu_clk(alu_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_irq_clr(cmd_irq_clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_irq(rsp_irq),
    .irq_cnt(irq_cnt),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_irq_clr(alu_irq_clr), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_out(alu_out), .alu_irq(alu_irq),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // ---------------- clock / reset block ----------------
  always #5 alu_clk = ~alu_clk;

  int cyc = 0;
  always @(posedge alu_clk) cyc <= cyc + 1;

  // ---------------- reference behaviour ----------------
  int  checks = 0;
  int  failures = 0;
  bit  force_irq = 1'b0;
  bit  rr_mode = 1'b0;
  int  accepted = 0;
  int  irq_cnt_model = 0;
  logic [8:0] exp_q[$];
  cmd_t       iss_q[$];
  int         hs_cyc[$];

  function automatic logic [7:0] ref_result(input logic unit, input logic [1:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
    if (unit == 1'b0) begin
      case (op)
        2'd0: return a & b;
        2'd1: return a | b;
        2'd2: return a ^ b;
        default: return a + b;
      endcase
    end else begin
      case (op)
        2'd0: return ~(a & b);
        2'd1: return ~(a ^ b);
        2'd2: return ~(a | b);
        default: return a - b;
      endcase
    end
  endfunction

  function automatic logic ref_irq(input logic [7:0] r, input logic clr, input bit force_it);
    return force_it || ((r == 8'h00) && !clr);
  endfunction

  // Registered ALU: result and irq appear the cycle after the enable pulse.
  always @(posedge alu_clk or posedge rst) begin
    if (rst) begin
      alu_out <= 8'h00;
      alu_irq <= 1'b0;
    end else if (alu_enable) begin
      alu_out <= alu_enable_a ? ref_result(1'b0, alu_op_a, alu_in_a, alu_in_b)
               : alu_enable_b ? ref_result(1'b1, alu_op_b, alu_in_a, alu_in_b) : 8'hEE;
      alu_irq <= ref_irq(alu_enable_a ? ref_result(1'b0, alu_op_a, alu_in_a, alu_in_b)
                         : ref_result(1'b1, alu_op_b, alu_in_a, alu_in_b), alu_irq_clr, force_irq);
    end else begin
      alu_out <= 8'h00;
      alu_irq <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit         prev_en = 1'b0;
  cmd_t       mon_c;
  logic [8:0] mon_e;

  always @(negedge alu_clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (alu_enable) begin
        check("pin_single_cycle", 64'(prev_en), 64'd0);
        if (iss_q.size() == 0) begin
          check("issue_unexpected", 64'd1, 64'd0);
        end else begin
          mon_c = iss_q.pop_front();
          check("alu_enable_a", 64'(alu_enable_a), 64'(mon_c.unit == 1'b0));
          check("alu_enable_b", 64'(alu_enable_b), 64'(mon_c.unit == 1'b1));
          check("alu_op_a", 64'(alu_op_a), (mon_c.unit == 1'b0) ? 64'(mon_c.op) : 64'd0);
          check("alu_op_b", 64'(alu_op_b), (mon_c.unit == 1'b1) ? 64'(mon_c.op) : 64'd0);
          check("alu_operands", 64'({alu_in_a, alu_in_b}), 64'({mon_c.a, mon_c.b}));
          check("alu_irq_clr", 64'(alu_irq_clr), 64'(mon_c.irq_clr));
        end
      end else begin
        check("pins_idle_zero", 64'({alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
                                     alu_in_a, alu_in_b, alu_irq_clr}), 64'd0);
      end
      prev_en = alu_enable;

      if (rsp_valid && rsp_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(mon_e[7:0]));
          check("rsp_irq", 64'(rsp_irq), 64'(mon_e[8]));
          if (mon_e[8] && irq_cnt_model < 255) irq_cnt_model++;
          check("irq_cnt", 64'(irq_cnt), 64'(irq_cnt_model));
        end
      end
    end
  end

  always @(posedge alu_clk) begin
    if (rr_mode) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic unit, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic clr);
    int   w;
    bit   ok;
    cmd_t c;
    logic [7:0] r;
    w = 0;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_unit = unit; cmd_op = op; cmd_a = a; cmd_b = b; cmd_irq_clr = clr;
    while (!ok && w < 200) begin
      @(negedge alu_clk);
      if (cmd_ready) ok = 1'b1;
      else w++;
    end
    if (!ok) begin
      check("cmd_accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
    end else begin
      c = '{unit: unit, op: op, a: a, b: b, irq_clr: clr};
      r = ref_result(unit, op, a, b);
      exp_q.push_back({ref_irq(r, clr, force_irq), r});
      iss_q.push_back(c);
      accepted++;
    end
    @(posedge alu_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_random();
    send_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge alu_clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge alu_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge alu_clk);
    @(negedge alu_clk);
    check("rst_rsp_outputs", 64'({cmd_ready, rsp_valid, rsp_data, rsp_irq, irq_cnt}), 64'd0);
    check("rst_alu_pins", 64'({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr,
                               alu_op_a, alu_op_b, alu_in_a, alu_in_b}), 64'd0);
    exp_q.delete();
    iss_q.delete();
    irq_cnt_model = 0;
    rst = 1'b0;
    @(negedge alu_clk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_irq_cnt", 64'(irq_cnt), 64'd0);
    check("post_rst_fifo_empty", 64'(dbg_count), 64'd0);
    @(posedge alu_clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int base;
    do_reset();

    // Unit A AND with latency measurement from the accepting edge.
    rsp_ready = 1'b1;
    send_cmd(1'b0, 2'b00, 8'hF0, 8'h3C, 1'b0);
    n = 0;
    do begin @(negedge alu_clk); n++; end while (!rsp_valid && n < 20);
    check("latency_unit_a", 64'(n), 64'd4);
    wait_drain();

    // Unit B NOR
    send_cmd(1'b1, 2'b10, 8'h0F, 8'hF0, 1'b0);
    wait_drain();

    // Random commands under random response backpressure.
    rr_mode = 1'b1;
    for (int i = 0; i < 80; i++) send_random();
    rr_mode = 1'b0;
    @(posedge alu_clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Backpressure: five fit (one in flight plus a full FIFO), the sixth waits.
    rsp_ready = 1'b0;
    base = accepted;
    for (int i = 0; i < 5; i++) send_random();
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge alu_clk);
      check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 64'(accepted - base), 64'd5);
    check("bp_fifo_count", 64'(dbg_count), 64'(DEPTH));
    @(posedge alu_clk);
    #1;
    hs_cyc.delete();
    rsp_ready = 1'b1;
    wait_drain();
    check("bp_rsp_count", 64'(hs_cyc.size()), 64'd5);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("bp_rsp_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);

    // IRQ counter saturation.
    do_reset();
    force_irq = 1'b1;
    for (int i = 0; i < 257; i++) send_random();
    wait_drain();
    check("irq_cnt_saturated", 64'(irq_cnt), 64'd255);
    force_irq = 1'b0;

    // Reset while in CAPTURE with two commands queued.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_random();
    check("midrst_in_capture", 64'(dbg_state), 64'(ST_CAPTURE));
    check("midrst_queued", 64'(dbg_count), 64'd2);
    rst = 1'b1;
    #1;
    check("midrst_pins_zero", 64'({alu_enable, alu_enable_a, alu_enable_b, alu_in_a, alu_in_b}), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(posedge alu_clk);
    exp_q.delete();
    iss_q.delete();
    irq_cnt_model = 0;
    #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge alu_clk);
      check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("midrst_fifo_empty", 64'(dbg_count), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
